pif_bus_decoder_n: RTL and testbench
====================================

# pif_bus_decoder_n

Parametrised address decoder, read-return multiplexer and ready arbiter for the PIF 6502 bus. It replaces the hand-written per-peripheral case blocks in the PIF top with N configurable base/mask regions. Each slave gets a one-hot chip-enable and write strobe. Read data and ready are returned from the registered address phase. An optional watchdog converts a hung slave access into an error completion, so the CPU never stalls forever.

## Interface
Parameters:
- NUM_SLAVES, 8, number of decoded regions (2..16); index NUM_SLAVES-1 is the default (catch-all) slave
- ADDR_W, 16, CPU address width
- DATA_W, 8, data width
- REGION_BASE, {NUM_SLAVES*ADDR_W{0}}, flattened base addresses; slave i at bits [i*ADDR_W +: ADDR_W]
- REGION_MASK, {NUM_SLAVES*ADDR_W{0}}, flattened compare masks; a 1 bit means that address bit is compared
- ALWAYS_RDY, {NUM_SLAVES{0}}, per-slave bit; 1 forces that slave's valid high (write-only or zero-wait slaves)
- TIMEOUT, 64, stall cycles before a forced error completion (1..255)
- ERR_DATA, 8'hFF, read data returned on a timed-out access

Ports:
- clk  in  1  system clock
- reset_l  in  1  asynchronous, active-low reset
- cpu_addr  in  ADDR_W  CPU address bus
- cpu_we  in  1  CPU write enable
- cpu_dout  in  DATA_W  CPU write data
- cs  in  1  global bus enable
- cpu_din  out  DATA_W  read data to CPU
- cpu_rdy  out  1  CPU RDY
- slv_oe  out  NUM_SLAVES  one-hot chip enable
- slv_wr  out  NUM_SLAVES  one-hot write strobe
- slv_wdata  out  DATA_W  equals cpu_dout
- slv_rdata  in  NUM_SLAVES*DATA_W  flattened slave read data
- slv_valid  in  NUM_SLAVES  per-slave data/ready valid
- bus_err  out  1  one-cycle pulse after a timeout completion
- err_addr  out  ADDR_W  address of the most recent timed-out access

## Operation
- Decode is combinational. Slave i matches when (cpu_addr & MASK_i) == (BASE_i & MASK_i).
- Priority is to the lowest index. For example, CRC at 0x328x/0x329x is placed at a lower index than the 0x3xxx-wide slave.
- If no region matches, the default slave NUM_SLAVES-1 is selected. The default slave's own mask is ignored.
- slv_oe = cs ? onehot(sel) : 0. slv_wr = slv_oe & {NUM_SLAVES{cpu_we}}.
- sel_q and addr_q are registered from sel and cpu_addr on every clk edge where cpu_rdy=1. While cpu_rdy=0 they hold their values.
- Return path:
  - cpu_din = slv_rdata[sel_q].
  - raw_rdy = slv_valid[sel_q] | ALWAYS_RDY[sel_q].
- FSM states:
  - IDLE: cpu_rdy = raw_rdy. If raw_rdy=0, go to WAIT and set cnt=1.
  - WAIT: cpu_rdy = raw_rdy. If raw_rdy=1, go to IDLE and set cnt=0. Else if cnt==TIMEOUT, go to TOUT. Else cnt++.
  - TOUT: cpu_rdy=1, cpu_din=ERR_DATA, err_addr<=addr_q, bus_err<=1 on the next cycle. Go to IDLE unconditionally.
- A write that times out is discarded: slv_wr has already been issued, and no retry is made.
- The bus_err pulse is exactly one cycle. Back-to-back timeouts produce separate pulses.

## Timing
- Reset values:
  - state=IDLE, cnt=0, sel_q=NUM_SLAVES-1, addr_q=0.
  - bus_err=0, err_addr=0.
  - cpu_rdy = raw_rdy of the default slave; cpu_din = that slave's rdata.
- slv_oe/slv_wr: zero latency from cpu_addr/cs.
- Read data and ready: valid in the cycle after the address (one-cycle registered phase).
- Timeout: cpu_rdy is 0 for exactly TIMEOUT cycles, then 1 for the single TOUT cycle.
- A slave valid that arrives in the same cycle cnt reaches TIMEOUT wins: the state goes to IDLE and no error is raised.
- Reset asserted mid-WAIT or mid-TOUT: all registers go to their reset values immediately, and no bus_err is raised.
- cnt width is 8 bits. cnt saturates and never wraps.

## Configuration
- PIF_BUS_TIMEOUT_EN:
  - Defined: the watchdog FSM, cnt, bus_err and err_addr are as described above.
  - Undefined: cpu_rdy = raw_rdy always, with no FSM or counter. bus_err is tied to 0 and err_addr is tied to 0.

## Test plan
- Reset: hold reset_l=0 -> bus_err=0, err_addr=0, sel_q=7. Release, drive cpu_addr=0xFFFC -> slv_oe=8'h80 and the default slave data appears on cpu_din the next cycle.
- Overlap priority: slave0 base 0x3280 mask 0xFFE0, slave3 base 0x3000 mask 0xF000; cpu_addr=0x3291 -> slv_oe=8'h01; cpu_addr=0x32C4 -> slv_oe=8'h08.
- Stall: slave1 valid low 5 cycles then high with rdata=0x5A -> cpu_rdy low 5 cycles, then cpu_din=0x5A; sel_q holds throughout.
- Timeout (macro on, TIMEOUT=4): slave2 never valid at 0x1234 -> cpu_rdy low 4 cycles, then 1 cycle high with cpu_din=0xFF; next cycle bus_err=1 and err_addr=0x1234.
- Race and reset: valid rises exactly at cnt==TIMEOUT -> no bus_err. Assert reset_l=0 in WAIT -> outputs return to reset values in the same cycle.
- Macro off: repeat the timeout case -> cpu_rdy stays 0 indefinitely, bus_err=0; ALWAYS_RDY slave with valid low -> cpu_rdy=1.

Source files
------------

// File: rtl/pif_bus_decoder_n.sv
// PIF 6502 bus decoder: base/mask region decode, registered read-return mux and ready path.
// Define PIF_BUS_TIMEOUT_EN to add the hung-access watchdog (error completion, bus_err, err_addr).
module pif_bus_decoder_n #(
  parameter int                           NUM_SLAVES  = 8,
  parameter int                           ADDR_W      = 16,
  parameter int                           DATA_W      = 8,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] REGION_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] REGION_MASK = '0,
  parameter logic [NUM_SLAVES-1:0]        ALWAYS_RDY  = '0,
  parameter int                           TIMEOUT     = 64,
  parameter logic [DATA_W-1:0]            ERR_DATA    = {DATA_W{1'b1}}
) (
  input  logic                         clk,
  input  logic                         reset_l,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic                         cpu_we,
  input  logic [DATA_W-1:0]            cpu_dout,
  input  logic                         cs,
  output logic [DATA_W-1:0]            cpu_din,
  output logic                         cpu_rdy,
  output logic [NUM_SLAVES-1:0]        slv_oe,
  output logic [NUM_SLAVES-1:0]        slv_wr,
  output logic [DATA_W-1:0]            slv_wdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] slv_rdata,
  input  logic [NUM_SLAVES-1:0]        slv_valid,
  output logic                         bus_err,
  output logic [ADDR_W-1:0]            err_addr
);

  localparam int              SEL_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [SEL_W-1:0] DEF_SEL = SEL_W'(NUM_SLAVES - 1);

  logic [NUM_SLAVES-1:0] w_match;
  logic [NUM_SLAVES-1:0] w_onehot;
  logic [NUM_SLAVES-1:0] w_rdy_vec;
  logic [DATA_W-1:0]     w_rd_arr [NUM_SLAVES];
  logic [SEL_W-1:0]      w_sel;
  logic [SEL_W-1:0]      r_sel_q;
  logic [DATA_W-1:0]     w_rd_data;
  logic                  w_raw_rdy;

  // The catch-all slave always matches; its own base/mask never take part.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
      if (gi == NUM_SLAVES - 1) begin : g_default
        assign w_match[gi] = 1'b1;
      end else begin : g_region
        assign w_match[gi] = ((cpu_addr & REGION_MASK[gi*ADDR_W +: ADDR_W]) ==
                              (REGION_BASE[gi*ADDR_W +: ADDR_W] & REGION_MASK[gi*ADDR_W +: ADDR_W]));
      end
      assign w_onehot[gi] = (w_sel == SEL_W'(gi));
      assign w_rd_arr[gi] = slv_rdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  always_comb begin
    w_sel = DEF_SEL;
    for (int i = NUM_SLAVES - 2; i >= 0; i--) begin
      if (w_match[i]) w_sel = SEL_W'(i);
    end
  end

  assign slv_oe    = cs ? w_onehot : '0;
  assign slv_wr    = slv_oe & {NUM_SLAVES{cpu_we}};
  assign slv_wdata = cpu_dout;

  assign w_rdy_vec = slv_valid | ALWAYS_RDY;
  assign w_raw_rdy = w_rdy_vec[r_sel_q];
  assign w_rd_data = w_rd_arr[r_sel_q];

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_sel_q <= DEF_SEL;
    end else if (cpu_rdy) begin
      r_sel_q <= w_sel;
    end
  end

`ifdef PIF_BUS_TIMEOUT_EN
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_TOUT} state_t;

  // ST_TOUT is the cycle in which cnt equals TIMEOUT, so cpu_rdy is low for
  // exactly TIMEOUT cycles; a valid arriving in that cycle still completes normally.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            r_state, w_state_next;
  logic [7:0]        r_cnt, w_cnt_next, w_cnt_inc;
  logic [ADDR_W-1:0] r_addr_q, r_err_addr;
  logic              r_bus_err;
  logic              w_rdy, w_force;

  assign w_cnt_inc = (r_cnt != 8'hFF) ? r_cnt + 8'd1 : r_cnt;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_rdy        = w_raw_rdy;
    w_force      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_raw_rdy) begin
          w_cnt_next   = 8'd1;
          w_state_next = (TIMEOUT <= 1) ? ST_TOUT : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_raw_rdy) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = 8'd0;
        end else begin
          w_cnt_next = w_cnt_inc;
          if (r_cnt >= CNT_LAST) w_state_next = ST_TOUT;
        end
      end
      ST_TOUT: begin
        w_rdy        = 1'b1;
        w_force      = !w_raw_rdy;
        w_state_next = ST_IDLE;
        w_cnt_next   = 8'd0;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 8'd0;
      r_addr_q   <= '0;
      r_bus_err  <= 1'b0;
      r_err_addr <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_bus_err <= w_force;
      if (w_rdy) r_addr_q <= cpu_addr;
      if (w_force) r_err_addr <= r_addr_q;
    end
  end

  assign cpu_rdy  = w_rdy;
  assign cpu_din  = w_force ? ERR_DATA : w_rd_data;
  assign bus_err  = r_bus_err;
  assign err_addr = r_err_addr;
`else
  assign cpu_rdy  = w_raw_rdy;
  assign cpu_din  = w_rd_data;
  assign bus_err  = 1'b0;
  assign err_addr = '0;
`endif

endmodule

// File: tb/tb_pif_bus_decoder_n.sv
// Directed bench for pif_bus_decoder_n: decode table, stall, ALWAYS_RDY, async reset,
// and (when PIF_BUS_TIMEOUT_EN is defined) timeout, race and reset-during-timeout.
module tb_pif_bus_decoder_n;
  localparam int NS = 8;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int TO = 4;
  localparam logic [NS*AW-1:0] BASE = {16'h0100, 16'h0000, 16'h8000, 16'h4000,
                                       16'h3000, 16'h1200, 16'h1000, 16'h3280};
  localparam logic [NS*AW-1:0] MASK = {16'hFF00, 16'hFF00, 16'hF000, 16'hC000,
                                       16'hF000, 16'hFF00, 16'hFF00, 16'hFFE0};
  localparam logic [NS-1:0] ARDY = 8'b0010_0000;

  logic             clk;
  logic             reset_l;
  logic [AW-1:0]    cpu_addr;
  logic             cpu_we;
  logic [DW-1:0]    cpu_dout;
  logic             cs;
  logic [DW-1:0]    cpu_din;
  logic             cpu_rdy;
  logic [NS-1:0]    slv_oe;
  logic [NS-1:0]    slv_wr;
  logic [DW-1:0]    slv_wdata;
  logic [NS*DW-1:0] slv_rdata;
  logic [NS-1:0]    slv_valid;
  logic             bus_err;
  logic [AW-1:0]    err_addr;
  logic [DW-1:0]    rd [NS];

  int n_vec = 0;
  int n_err = 0;

  for (genvar gi = 0; gi < NS; gi++) begin : g_rd
    assign slv_rdata[gi*DW +: DW] = rd[gi];
  end

  pif_bus_decoder_n #(
    .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .REGION_BASE(BASE), .REGION_MASK(MASK),
    .ALWAYS_RDY(ARDY), .TIMEOUT(TO), .ERR_DATA(8'hFF)
  ) dut (
    .clk(clk), .reset_l(reset_l), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_dout(cpu_dout),
    .cs(cs), .cpu_din(cpu_din), .cpu_rdy(cpu_rdy), .slv_oe(slv_oe), .slv_wr(slv_wr),
    .slv_wdata(slv_wdata), .slv_rdata(slv_rdata), .slv_valid(slv_valid), .bus_err(bus_err),
    .err_addr(err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic        cs;
    logic [7:0]  dout;
    logic [7:0]  exp_oe;
    logic [7:0]  exp_wr;
    logic [7:0]  exp_din;
  } vec_t;

  vec_t vt [17];

  initial begin
    vt[0]  = '{16'h3291, 1'b0, 1'b1, 8'h11, 8'h01, 8'h00, 8'hA0};
    vt[1]  = '{16'h32C4, 1'b0, 1'b1, 8'h22, 8'h08, 8'h00, 8'hA3};
    vt[2]  = '{16'h1005, 1'b1, 1'b1, 8'h33, 8'h02, 8'h02, 8'hA1};
    vt[3]  = '{16'h12FF, 1'b0, 1'b1, 8'h44, 8'h04, 8'h00, 8'hA2};
    vt[4]  = '{16'h5ABC, 1'b1, 1'b1, 8'h55, 8'h10, 8'h10, 8'hA4};
    vt[5]  = '{16'h8123, 1'b0, 1'b1, 8'h66, 8'h20, 8'h00, 8'hA5};
    vt[6]  = '{16'h0042, 1'b1, 1'b1, 8'h77, 8'h40, 8'h40, 8'hA6};
    vt[7]  = '{16'hFFFC, 1'b0, 1'b1, 8'h88, 8'h80, 8'h00, 8'hA7};
    vt[8]  = '{16'h0150, 1'b1, 1'b1, 8'h99, 8'h80, 8'h80, 8'hA7};
    vt[9]  = '{16'h3291, 1'b1, 1'b0, 8'hAA, 8'h00, 8'h00, 8'hA0};
    vt[10] = '{16'h329F, 1'b0, 1'b1, 8'hBB, 8'h01, 8'h00, 8'hA0};
    vt[11] = '{16'h32A0, 1'b0, 1'b1, 8'hCC, 8'h08, 8'h00, 8'hA3};
    vt[12] = '{16'h3FFF, 1'b1, 1'b1, 8'hDD, 8'h08, 8'h08, 8'hA3};
    vt[13] = '{16'h2FFF, 1'b0, 1'b1, 8'hEE, 8'h80, 8'h00, 8'hA7};
    vt[14] = '{16'h4000, 1'b1, 1'b0, 8'h01, 8'h00, 8'h00, 8'hA4};
    vt[15] = '{16'h7FFF, 1'b0, 1'b1, 8'h02, 8'h10, 8'h00, 8'hA4};
    vt[16] = '{16'hC000, 1'b0, 1'b1, 8'h03, 8'h80, 8'h00, 8'hA7};

    for (int i = 0; i < NS; i++) rd[i] = 8'(8'hA0 + i);
    slv_valid = 8'hFF;
    reset_l   = 1'b0;
    cs        = 1'b1;
    cpu_we    = 1'b0;
    cpu_dout  = 8'h00;
    cpu_addr  = 16'h1005;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_bus_err", 32'(bus_err), 0);
    chk("rst_err_addr", 32'(err_addr), 0);
    chk("rst_din_default", 32'(cpu_din), 'hA7);
    chk("rst_rdy_default", 32'(cpu_rdy), 1);
    chk("rst_oe_comb", 32'(slv_oe), 'h02);
    reset_l  = 1'b1;
    cpu_addr = 16'hFFFC;
    #1 chk("post_rst_oe", 32'(slv_oe), 'h80);
    @(negedge clk);
    chk("post_rst_din", 32'(cpu_din), 'hA7);

    // Decode table: comb outputs now, registered return path one cycle later
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("vec_din", 32'(cpu_din), 32'(vt[i-1].exp_din));
        chk("vec_rdy", 32'(cpu_rdy), 1);
      end
      cpu_addr = vt[i].addr;
      cpu_we   = vt[i].we;
      cs       = vt[i].cs;
      cpu_dout = vt[i].dout;
      #1;
      chk("vec_oe", 32'(slv_oe), 32'(vt[i].exp_oe));
      chk("vec_wr", 32'(slv_wr), 32'(vt[i].exp_wr));
      chk("vec_wdata", 32'(slv_wdata), 32'(vt[i].dout));
      $display("vec %0d addr=%h we=%b cs=%b oe=%h wr=%h", i, cpu_addr, cpu_we, cs, slv_oe, slv_wr);
    end
    @(negedge clk);
    chk("vec_din_last", 32'(cpu_din), 32'(vt[16].exp_din));
    cs     = 1'b1;
    cpu_we = 1'b0;

    // Stall on slave1 for 3 cycles; the address moves but sel_q must hold
    rd[1] = 8'h5A;
    slv_valid[1] = 1'b0;
    cpu_addr = 16'h1005;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_rdy_low", 32'(cpu_rdy), 0);
      if (k == 0) cpu_addr = 16'h0042;
    end
    slv_valid[1] = 1'b1;
    #1;
    chk("stall_rdy_high", 32'(cpu_rdy), 1);
    chk("stall_din", 32'(cpu_din), 'h5A);
    @(negedge clk);
    chk("stall_next_din", 32'(cpu_din), 'hA6);
    rd[1] = 8'hA1;
    $display("seq stall: done");

    // ALWAYS_RDY slave with valid low
    slv_valid[5] = 1'b0;
    cpu_addr = 16'h8123;
    @(negedge clk);
    chk("ardy_rdy", 32'(cpu_rdy), 1);
    chk("ardy_din", 32'(cpu_din), 'hA5);
    slv_valid[5] = 1'b1;
    cpu_addr = 16'h0042;
    @(negedge clk);
    $display("seq always_rdy: done");

`ifdef PIF_BUS_TIMEOUT_EN
    // Timeout on slave2 at 0x1234
    slv_valid[2] = 1'b0;
    cpu_addr = 16'h1234;
    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      chk("to_rdy_low", 32'(cpu_rdy), 0);
      chk("to_no_err", 32'(bus_err), 0);
    end
    @(negedge clk);
    chk("to_rdy_tout", 32'(cpu_rdy), 1);
    chk("to_din_err", 32'(cpu_din), 'hFF);
    chk("to_err_not_yet", 32'(bus_err), 0);
    cpu_addr = 16'h0042;
    @(negedge clk);
    chk("to_bus_err", 32'(bus_err), 1);
    chk("to_err_addr", 32'(err_addr), 'h1234);
    chk("to_after_din", 32'(cpu_din), 'hA6);
    @(negedge clk);
    chk("to_pulse_end", 32'(bus_err), 0);
    $display("seq timeout: done");

    // Valid arrives in the cycle cnt reaches TIMEOUT
    cpu_addr = 16'h1234;
    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      chk("race_rdy_low", 32'(cpu_rdy), 0);
    end
    @(negedge clk);
    slv_valid[2] = 1'b1;
    cpu_addr = 16'h0042;
    #1;
    chk("race_rdy", 32'(cpu_rdy), 1);
    chk("race_din", 32'(cpu_din), 'hA2);
    @(negedge clk);
    chk("race_no_err", 32'(bus_err), 0);
    $display("seq race: done");

    // Reset asserted mid-WAIT
    slv_valid[2] = 1'b0;
    cpu_addr = 16'h1234;
    repeat (3) @(negedge clk);
    chk("rw_rdy_low", 32'(cpu_rdy), 0);
    reset_l = 1'b0;
    #1;
    chk("rw_err_addr", 32'(err_addr), 0);
    chk("rw_bus_err", 32'(bus_err), 0);
    chk("rw_din", 32'(cpu_din), 'hA7);
    chk("rw_rdy", 32'(cpu_rdy), 1);
    cpu_addr = 16'h0042;
    @(negedge clk);
    reset_l = 1'b1;
    @(negedge clk);
    chk("rw_after_err", 32'(bus_err), 0);

    // Reset asserted in the forced-completion cycle
    cpu_addr = 16'h1234;
    for (int k = 0; k < TO; k++) @(negedge clk);
    @(negedge clk);
    chk("rt_din_err", 32'(cpu_din), 'hFF);
    reset_l = 1'b0;
    cpu_addr = 16'h0042;
    #1;
    chk("rt_din_reset", 32'(cpu_din), 'hA7);
    @(negedge clk);
    chk("rt_no_err", 32'(bus_err), 0);
    chk("rt_err_addr", 32'(err_addr), 0);
    reset_l = 1'b1;
    slv_valid[2] = 1'b1;
    @(negedge clk);
    $display("seq reset_in_wait_tout: done");
`else
    // Without the watchdog a hung slave stalls indefinitely
    slv_valid[2] = 1'b0;
    cpu_addr = 16'h1234;
    for (int k = 0; k < 3 * TO; k++) begin
      @(negedge clk);
      chk("hang_rdy_low", 32'(cpu_rdy), 0);
      chk("hang_no_err", 32'(bus_err), 0);
      chk("hang_err_addr", 32'(err_addr), 0);
    end
    slv_valid[2] = 1'b1;
    #1;
    chk("hang_release_rdy", 32'(cpu_rdy), 1);
    chk("hang_release_din", 32'(cpu_din), 'hA2);
    slv_valid[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("hang2_rdy_low", 32'(cpu_rdy), 0);
    reset_l = 1'b0;
    #1;
    chk("hang_rst_din", 32'(cpu_din), 'hA7);
    chk("hang_rst_rdy", 32'(cpu_rdy), 1);
    cpu_addr = 16'h0042;
    @(negedge clk);
    reset_l = 1'b1;
    slv_valid[2] = 1'b1;
    @(negedge clk);
    chk("hang_after_din", 32'(cpu_din), 'hA6);
    $display("seq no_watchdog: done");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
